pc_btb: RTL

PC_BTB -- requirements
Module: pc_btb

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/pc_btb_if.sv | 28 ++
 rtl/btb_table.sv | 61 ++++++
 rtl/pc_btb.sv | 80 ++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared fetch/BTB types: 2-bit direction counter, BTB entry layout and counter update rule.
package cpu_types_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned TGT_W     = 30;
    // Widest tag (BTB_ENTRIES = 2); narrower tags are zero-extended into this field.
    localparam int unsigned TAG_MAX_W = 29;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } ctr_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [TGT_W-1:0]     target;
        ctr_e                 ctr;
    } btb_entry_t;

    // Saturating step of the direction counter toward the resolved outcome.
    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        ctr_e r;
        r = c;
        unique case (c)
            CNT_SNT: r = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: r = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  r = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  r = taken ? CNT_ST  : CNT_WT;
            default: r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_btb_if.sv
// Fetch-side bus: PC/prediction outputs plus resolve and redirect inputs.
interface pc_btb_if;
    import cpu_types_pkg::*;

    logic            pcEN;
    logic [XLEN-1:0] cpc;
    logic [XLEN-1:0] npc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            resolve_valid;
    logic [XLEN-1:0] resolve_pc;
    logic            resolve_taken;
    logic [XLEN-1:0] resolve_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output pcEN, resolve_valid, resolve_pc, resolve_taken, resolve_target,
               redirect, redirect_pc,
        input  cpc, npc, pred_taken, pred_target
    );

    modport slave (
        input  pcEN, resolve_valid, resolve_pc, resolve_taken, resolve_target,
               redirect, redirect_pc,
        output cpc, npc, pred_taken, pred_target
    );
endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational lookup port, synchronous read-modify-write update port.
module btb_table
    import cpu_types_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [IDX_W-1:0]     rd_idx,
    output btb_entry_t           rd_entry_c,
    input  logic                 upd_en,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic [TAG_MAX_W-1:0] upd_tag,
    input  logic                 upd_taken,
    input  logic [TGT_W-1:0]     upd_target
);

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_MAX_W-1:0] tag_q    [ENTRIES];
    logic [TGT_W-1:0]     target_q [ENTRIES];
    ctr_e                 ctr_q    [ENTRIES];

    logic upd_hit_c;

    always_comb begin
        rd_entry_c        = '0;
        rd_entry_c.valid  = valid_q[rd_idx];
        rd_entry_c.tag    = tag_q[rd_idx];
        rd_entry_c.target = target_q[rd_idx];
        rd_entry_c.ctr    = ctr_q[rd_idx];
    end

    assign upd_hit_c = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Only valid bits are reset; a hit already has valid set, a taken miss allocates.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (upd_en && upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Payload writes during reset are harmless: the entry stays invalid.
    always_ff @(posedge CLK) begin
        if (upd_en) begin
            if (upd_hit_c) begin
                ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken);
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= CNT_WT;
            end
        end
    end

endmodule

// File: rtl/pc_btb.sv
// Fetch PC register with direct-mapped branch target buffer prediction and redirect.
module pc_btb
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic     CLK,
    input  logic     nRST,
    pc_btb_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    // Word-aligned PC; the two low bits are implicitly 00.
    logic [TGT_W-1:0]     pc_q;
    logic [TGT_W-1:0]     pc_d;
    logic [XLEN-1:0]      cpc_c;
    logic [XLEN-1:0]      npc_c;
    logic [IDX_W-1:0]     lk_idx;
    logic [TAG_MAX_W-1:0] lk_tag;
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_MAX_W-1:0] up_tag;
    btb_entry_t           lk_entry_c;
    logic                 pred_taken_c;
    logic                 unused_lsbs;

    assign cpc_c  = {pc_q, 2'b00};
    assign npc_c  = cpc_c + 32'd4;

    assign lk_idx = pc_q[IDX_W-1:0];
    assign lk_tag = TAG_MAX_W'(pc_q[IDX_W +: TAG_W]);
    assign up_idx = bus.resolve_pc[IDX_W+1:2];
    assign up_tag = TAG_MAX_W'(bus.resolve_pc[31:IDX_W+2]);

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb_table (
        .CLK        (CLK),
        .nRST       (nRST),
        .rd_idx     (lk_idx),
        .rd_entry_c (lk_entry_c),
        .upd_en     (bus.resolve_valid),
        .upd_idx    (up_idx),
        .upd_tag    (up_tag),
        .upd_taken  (bus.resolve_taken),
        .upd_target (bus.resolve_target[31:2])
    );

    assign pred_taken_c    = lk_entry_c.valid && (lk_entry_c.tag == lk_tag) && lk_entry_c.ctr[1];

    assign bus.cpc         = cpc_c;
    assign bus.npc         = npc_c;
    assign bus.pred_taken  = pred_taken_c;
    assign bus.pred_target = {lk_entry_c.target, 2'b00};

    assign unused_lsbs = ^{bus.redirect_pc[1:0], bus.resolve_target[1:0],
                           bus.resolve_pc[1:0], npc_c[1:0]};

    // Next-PC priority: redirect, then predicted target, then sequential, else hold.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc[31:2];
        end else if (bus.pcEN) begin
            pc_d = pred_taken_c ? lk_entry_c.target : npc_c[31:2];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_INIT[31:2];
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
